// File: rtl/sw_seq_loader.sv
// sw_seq_loader: ASCII base-stream front end for smith_waterman.
// Parses records of the form <ref bases> '|' <query bases> '\n', packs each
// base into 2 bits (first base in the MSB slot) and holds the finished
// record on the outputs until the consumer acknowledges it.
// Build option: define SW_LOADER_LOWERCASE_EN to accept 'a','t','g','c'
// with the same codes as upper case. Left undefined, they are rejected.
//
// state        | meaning
// S_LOAD_REF   | collecting reference bases until '|'
// S_LOAD_QUERY | collecting query bases until '\n'
// S_DONE       | record complete, outputs held, input stalled until seq_ack
// S_FLUSH      | malformed record dropped, discarding bytes through '\n'
module sw_seq_loader #(
  parameter int REF_LEN    = 15,
  parameter int QUERY_LEN  = 10,
  parameter int BASE_WIDTH = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [7:0]                      in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [REF_LEN*BASE_WIDTH-1:0]   ref_seq,
  output logic [QUERY_LEN*BASE_WIDTH-1:0] query_seq,
  output logic [7:0]                      ref_len,
  output logic [7:0]                      query_len,
  output logic                            seq_valid,
  input  logic                            seq_ack,
  output logic                            err_char
);

  localparam logic [7:0] REF_MAX   = 8'(REF_LEN);
  localparam logic [7:0] QUERY_MAX = 8'(QUERY_LEN);
  localparam logic [7:0] CH_BAR    = 8'h7C;
  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] CH_CR     = 8'h0D;

  typedef enum logic [1:0] {
    S_LOAD_REF,
    S_LOAD_QUERY,
    S_DONE,
    S_FLUSH
  } state_t;

  state_t                            state;
  state_t                            state_n;
  logic [REF_LEN*BASE_WIDTH-1:0]     ref_n;
  logic [QUERY_LEN*BASE_WIDTH-1:0]   query_n;
  logic [7:0]                        rlen_n;
  logic [7:0]                        qlen_n;
  logic                              err_n;
  logic                              bad;
  logic                              accept;
  logic [2:0]                        dec;

  // Returns {is_base, code}; code is only meaningful when is_base is set.
  function automatic logic [2:0] decode_base(input logic [7:0] ch);
    logic [7:0] c;
    c = ch;
`ifdef SW_LOADER_LOWERCASE_EN
    if (ch >= 8'h61 && ch <= 8'h7A) c = ch - 8'h20;
`endif
    case (c)
      8'h41:   decode_base = 3'b1_00;
      8'h54:   decode_base = 3'b1_01;
      8'h47:   decode_base = 3'b1_10;
      8'h43:   decode_base = 3'b1_11;
      default: decode_base = 3'b0_00;
    endcase
  endfunction

  // Ready is held low while in reset so nothing is taken before the FSM is known.
  assign in_ready  = rst && (state != S_DONE);
  assign seq_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready;
  assign dec       = decode_base(in_data);

  // Next-state, packing and error decision for the byte on the input.
  always_comb begin
    state_n = state;
    ref_n   = ref_seq;
    query_n = query_seq;
    rlen_n  = ref_len;
    qlen_n  = query_len;
    err_n   = 1'b0;
    bad     = 1'b0;
    case (state)
      S_LOAD_REF: begin
        if (accept) begin
          if (dec[2]) begin
            if (ref_len < REF_MAX) begin
              for (int i = 0; i < REF_LEN; i++) begin
                if (ref_len == 8'(i))
                  ref_n[(REF_LEN-1-i)*BASE_WIDTH +: BASE_WIDTH] = dec[1:0];
              end
              rlen_n = ref_len + 8'd1;
            end else begin
              bad = 1'b1;
            end
          end else if (in_data == CH_BAR && ref_len != 8'd0) begin
            state_n = S_LOAD_QUERY;
          end else if (in_data != CH_CR) begin
            bad = 1'b1;
          end
        end
      end
      S_LOAD_QUERY: begin
        if (accept) begin
          if (dec[2]) begin
            if (query_len < QUERY_MAX) begin
              for (int i = 0; i < QUERY_LEN; i++) begin
                if (query_len == 8'(i))
                  query_n[(QUERY_LEN-1-i)*BASE_WIDTH +: BASE_WIDTH] = dec[1:0];
              end
              qlen_n = query_len + 8'd1;
            end else begin
              bad = 1'b1;
            end
          end else if (in_data == CH_LF && query_len != 8'd0) begin
            state_n = S_DONE;
          end else if (in_data != CH_CR) begin
            bad = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (seq_ack) begin
          ref_n   = '0;
          query_n = '0;
          rlen_n  = 8'd0;
          qlen_n  = 8'd0;
          state_n = S_LOAD_REF;
        end
      end
      S_FLUSH: begin
        if (accept && in_data == CH_LF) state_n = S_LOAD_REF;
      end
      default: state_n = S_LOAD_REF;
    endcase

    // A '\n' that is itself the offence already ends the record, so no flush.
    if (bad) begin
      ref_n   = '0;
      query_n = '0;
      rlen_n  = 8'd0;
      qlen_n  = 8'd0;
      err_n   = 1'b1;
      state_n = (in_data == CH_LF) ? S_LOAD_REF : S_FLUSH;
    end
  end

  // State, record registers and error pulse, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_LOAD_REF;
      ref_seq   <= '0;
      query_seq <= '0;
      ref_len   <= 8'd0;
      query_len <= 8'd0;
      err_char  <= 1'b0;
    end else begin
      state     <= state_n;
      ref_seq   <= ref_n;
      query_seq <= query_n;
      ref_len   <= rlen_n;
      query_len <= qlen_n;
      err_char  <= err_n;
    end
  end

endmodule

// File: tb/tb_sw_seq_loader.sv
// Bench for sw_seq_loader: fixed record table, hand-written corner cases,
// then random records scored against a line-level model of the record rules.
module tb_sw_seq_loader;

  localparam int REF_LEN   = 15;
  localparam int QUERY_LEN = 10;
  localparam int RW        = REF_LEN * 2;
  localparam int QW        = QUERY_LEN * 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [RW-1:0] ref_seq;
  logic [QW-1:0] query_seq;
  logic [7:0]    ref_len;
  logic [7:0]    query_len;
  logic          seq_valid;
  logic          seq_ack = 1'b0;
  logic          err_char;

  int tests = 0;
  int failed = 0;
  int err_cnt = 0;

  sw_seq_loader #(.REF_LEN(REF_LEN), .QUERY_LEN(QUERY_LEN), .BASE_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ref_seq(ref_seq), .query_seq(query_seq),
    .ref_len(ref_len), .query_len(query_len), .seq_valid(seq_valid),
    .seq_ack(seq_ack), .err_char(err_char)
  );

  always #5 clk = ~clk;

  // Counts the cycles on which err_char is high.
  always @(negedge clk) if (err_char) err_cnt++;

  typedef struct {
    string         line;
    bit            ok;
    logic [RW-1:0] rs;
    logic [QW-1:0] qs;
    int            rl;
    int            ql;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int base_code(input byte c);
    byte u;
    u = c;
`ifdef SW_LOADER_LOWERCASE_EN
    if (c >= 8'h61 && c <= 8'h7A) u = c - 8'h20;
`endif
    case (u)
      8'h41:   return 0;
      8'h54:   return 1;
      8'h47:   return 2;
      8'h43:   return 3;
      default: return -1;
    endcase
  endfunction

  // Whole-line model: a line is a record iff, ignoring CRs, it is
  // <1..REF_LEN bases> '|' <1..QUERY_LEN bases>; anything else is one error.
  function automatic void model_line(input string s, output bit ok,
                                     output logic [RW-1:0] rs, output logic [QW-1:0] qs,
                                     output int rl, output int ql);
    int bars;
    int part;
    int code;
    byte c;
    bars = 0; part = 0; rl = 0; ql = 0; rs = '0; qs = '0; ok = 1'b1;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c == 8'h0D) continue;
      if (c == 8'h7C) begin bars++; part = 1; continue; end
      code = base_code(c);
      if (code < 0) ok = 1'b0;
      else if (part == 0) begin rs = {rs[RW-3:0], 2'(code)}; rl++; end
      else begin qs = {qs[QW-3:0], 2'(code)}; ql++; end
    end
    if (bars != 1 || rl == 0 || ql == 0 || rl > REF_LEN || ql > QUERY_LEN) ok = 1'b0;
    if (ok) begin
      rs = rs << (2 * (REF_LEN - rl));
      qs = qs << (2 * (QUERY_LEN - ql));
    end else begin
      rs = '0; qs = '0; rl = 0; ql = 0;
    end
  endfunction

  function automatic string ch(input byte c);
    string t;
    t = " ";
    t.putc(0, c);
    return t;
  endfunction

  // Called at a point away from the clock edge; returns just after the accepting edge.
  task automatic send_byte(input byte b, input int gap, input bit rnd_ack);
    int guard;
    guard = 0;
    in_data  = b;
    in_valid = 1'b1;
    seq_ack  = rnd_ack ? 1'($urandom_range(0, 1)) : 1'b0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    seq_ack  = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic ack_record();
    seq_ack = 1'b1;
    @(posedge clk); #1;
    seq_ack = 1'b0;
    @(negedge clk); #1;
    check("ack_seq_valid", 32'(seq_valid), 32'd0);
    check("ack_in_ready", 32'(in_ready), 32'd1);
    check("ack_ref_len", 32'(ref_len), 32'd0);
    check("ack_ref_seq", 32'(ref_seq), 32'd0);
  endtask

  task automatic run_line(input string s, input bit ok, input logic [RW-1:0] rs,
                          input logic [QW-1:0] qs, input int rl, input int ql,
                          input int gapmax, input bit rnd_ack);
    int e0;
    e0 = err_cnt;
    for (int i = 0; i < s.len(); i++)
      send_byte(s[i], $urandom_range(0, gapmax), rnd_ack);
    send_byte(8'h0A, 0, rnd_ack);
    @(negedge clk); #1;
    check("err_pulses", 32'(err_cnt - e0), ok ? 32'd0 : 32'd1);
    check("seq_valid", 32'(seq_valid), 32'(ok));
    if (ok) begin
      check("ref_seq", 32'(ref_seq), 32'(rs));
      check("query_seq", 32'(query_seq), 32'(qs));
      check("ref_len", 32'(ref_len), 32'(rl));
      check("query_len", 32'(query_len), 32'(ql));
      ack_record();
    end else begin
      check("err_ref_len", 32'(ref_len), 32'd0);
      check("err_in_ready", 32'(in_ready), 32'd1);
    end
  endtask

  task automatic random_line(output string s);
    string bases;
    string bad;
    int kind, nr, nq;
    bases = "ATGC";
    bad   = "N|x\rtZ";
    kind = $urandom_range(0, 9);
    nr = $urandom_range(1, REF_LEN);
    nq = $urandom_range(1, QUERY_LEN);
    if (kind == 7) nr = REF_LEN + 1;
    if (kind == 8) nq = QUERY_LEN + 1;
    if (kind == 9) nr = 0;
    s = "";
    for (int i = 0; i < nr; i++) begin
      s = {s, ch(bases[$urandom_range(0, 3)])};
      if ($urandom_range(0, 15) == 0) s = {s, "\r"};
    end
    s = {s, "|"};
    for (int i = 0; i < nq; i++) begin
      s = {s, ch(bases[$urandom_range(0, 3)])};
      if ($urandom_range(0, 15) == 0) s = {s, "\r"};
    end
    if (kind == 6) s.putc($urandom_range(0, s.len() - 1), bad[$urandom_range(0, 5)]);
  endtask

  initial begin
    string s;
    bit ok;
    logic [RW-1:0] rs;
    logic [QW-1:0] qs;
    int rl, ql;

    tbl.push_back('{"GTATGCATTGCATGG|ATGCATTGCA", 1'b1, 30'h246C5B1A, 20'h1B16C, 15, 10});
    tbl.push_back('{"GA|C",          1'b1, 30'h20000000, 20'hC0000, 2, 1});
    tbl.push_back('{"GNA|C",         1'b0, 30'h0, 20'h0, 0, 0});
    tbl.push_back('{"A|T",           1'b1, 30'h0, 20'h40000, 1, 1});
    tbl.push_back('{"GGGGGGGGGGGGGGGG|A", 1'b0, 30'h0, 20'h0, 0, 0});
    tbl.push_back('{"C|A",           1'b1, 30'h30000000, 20'h0, 1, 1});
    tbl.push_back('{"|A",            1'b0, 30'h0, 20'h0, 0, 0});
    tbl.push_back('{"A|",            1'b0, 30'h0, 20'h0, 0, 0});
    tbl.push_back('{"",              1'b0, 30'h0, 20'h0, 0, 0});
    tbl.push_back('{"A|C|G",         1'b0, 30'h0, 20'h0, 0, 0});
    tbl.push_back('{"AC\rG|T\r",     1'b1, 30'h0E000000, 20'h40000, 3, 1});
    tbl.push_back('{"ACGT|TTTTTTTTTTT", 1'b0, 30'h0, 20'h0, 0, 0});
    tbl.push_back('{"TTTTTTTTTTTTTTT|CCCCCCCCCC", 1'b1, 30'h15555555, 20'hFFFFF, 15, 10});
`ifdef SW_LOADER_LOWERCASE_EN
    tbl.push_back('{"a|c",           1'b1, 30'h0, 20'hC0000, 1, 1});
`else
    tbl.push_back('{"a|c",           1'b0, 30'h0, 20'h0, 0, 0});
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_seq_valid", 32'(seq_valid), 32'd0);
    check("rst_err", 32'(err_char), 32'd0);
    check("rst_ref_len", 32'(ref_len), 32'd0);
    check("rst_query_seq", 32'(query_seq), 32'd0);
    rst = 1'b1;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // Fixed records
    foreach (tbl[i])
      run_line(tbl[i].line, tbl[i].ok, tbl[i].rs, tbl[i].qs, tbl[i].rl, tbl[i].ql, 0, 1'b0);

    // Backpressure in DONE: held byte must not be consumed
    s = "GA|C";
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 0, 1'b0);
    send_byte(8'h0A, 0, 1'b0);
    in_data  = 8'h54;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_seq_valid", 32'(seq_valid), 32'd1);
      check("bp_ref_seq", 32'(ref_seq), 32'h20000000);
      check("bp_ref_len", 32'(ref_len), 32'd2);
    end
    in_valid = 1'b0;
    ack_record();
    run_line("A|T", 1'b1, 30'h0, 20'h40000, 1, 1, 0, 1'b0);

    // Reset in the middle of a record
    s = "GAT";
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 0, 1'b0);
    check("mid_ref_len", 32'(ref_len), 32'd3);
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_ref_len", 32'(ref_len), 32'd0);
    check("mid_rst_ref_seq", 32'(ref_seq), 32'd0);
    rst = 1'b1;
    #1;
    run_line("C|A", 1'b1, 30'h30000000, 20'h0, 1, 1, 0, 1'b0);

    // Random records with idle gaps and stray seq_ack while loading
    for (int n = 0; n < 80; n++) begin
      random_line(s);
      model_line(s, ok, rs, qs, rl, ql);
      run_line(s, ok, rs, qs, rl, ql, 2, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
